// File: rtl/weight_prefetch_feeder_if.sv
// Weight-load bus of the systolic array: SRAM read port on one side,
// top-of-column w_data/w_valid/prefetch chain on the other.
interface weight_prefetch_feeder_if #(
   parameter int W_BITWIDTH = 8,
   parameter int COL_NUM    = 16,
   parameter int ADDR_WIDTH = 10
);
   logic                          rd_en;
   logic [ADDR_WIDTH-1:0]         rd_addr;
   logic [COL_NUM*W_BITWIDTH-1:0] rd_data;
   logic                          prefetch_out;
   logic [COL_NUM*W_BITWIDTH-1:0] w_data_out;
   logic                          w_valid_out;

   // master is the feeder; slave is the SRAM plus the PE column it drives
   modport master (
      output rd_en, rd_addr, prefetch_out, w_data_out, w_valid_out,
      input  rd_data
   );

   modport slave (
      input  rd_en, rd_addr, prefetch_out, w_data_out, w_valid_out,
      output rd_data
   );
endinterface

// File: rtl/weight_prefetch_feeder.sv
// Reads one weight tile from SRAM bottom row first and streams it down the
// PE columns so every row latches its weight on the same edge.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// ISSUE | ROW_NUM read strobes, addresses tile_base+ROW_NUM-1 down to tile_base
// DRAIN | no reads; waits RD_LATENCY+1 cycles for the last beat to leave
// DONE  | one-cycle done pulse; start here chains the next tile
module weight_prefetch_feeder #(
   parameter int W_BITWIDTH = 8,
   parameter int ROW_NUM    = 27,
   parameter int COL_NUM    = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] tile_base,
   output logic                  busy,
   output logic                  done,
   weight_prefetch_feeder_if.master bus
);

   localparam int CW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
   localparam int DW = $clog2(RD_LATENCY + 1);
   localparam int LW = COL_NUM * W_BITWIDTH;

   localparam logic [CW-1:0]         ROW_LAST  = CW'(ROW_NUM - 1);
   localparam logic [DW-1:0]         DRAIN_LEN = DW'(RD_LATENCY);
   localparam logic [ADDR_WIDTH-1:0] ADDR_SPAN = ADDR_WIDTH'(ROW_NUM - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         row_cnt, row_cnt_nxt;
   logic [DW-1:0]         drain_cnt, drain_cnt_nxt;
   logic                  rd_en_q, rd_en_nxt;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_nxt;
   logic                  prefetch_q, prefetch_nxt;
   logic [RD_LATENCY-1:0] vld_sr;
   logic                  w_valid_q;
   logic [LW-1:0]         w_data_q;

   assign busy = (state == S_ISSUE) || (state == S_DRAIN);
   assign done = (state == S_DONE);

   assign bus.rd_en        = rd_en_q;
   assign bus.rd_addr      = rd_addr_q;
   assign bus.prefetch_out = prefetch_q;
   assign bus.w_valid_out  = w_valid_q;
   assign bus.w_data_out   = w_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         row_cnt    <= '0;
         drain_cnt  <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         prefetch_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         row_cnt    <= row_cnt_nxt;
         drain_cnt  <= drain_cnt_nxt;
         rd_en_q    <= rd_en_nxt;
         rd_addr_q  <= rd_addr_nxt;
         prefetch_q <= prefetch_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      row_cnt_nxt   = row_cnt;
      drain_cnt_nxt = drain_cnt;
      rd_en_nxt     = 1'b0;
      rd_addr_nxt   = rd_addr_q;
      prefetch_nxt  = 1'b0;

      case (state)
         S_IDLE, S_DONE: begin
            state_nxt = S_IDLE;
            if (start) begin
               state_nxt    = S_ISSUE;
               row_cnt_nxt  = ROW_LAST;
               rd_en_nxt    = 1'b1;
               prefetch_nxt = 1'b1;
               rd_addr_nxt  = tile_base + ADDR_SPAN;
            end
         end
         S_ISSUE: begin
            // row_cnt is the number of reads still to issue after this one
            if (row_cnt == '0) begin
               state_nxt     = S_DRAIN;
               drain_cnt_nxt = DRAIN_LEN;
            end else begin
               row_cnt_nxt = row_cnt - CW'(1);
               rd_en_nxt   = 1'b1;
               rd_addr_nxt = rd_addr_q - ADDR_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            if (drain_cnt == '0) begin
               state_nxt = S_DONE;
            end else begin
               drain_cnt_nxt = drain_cnt - DW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // vld_sr[RD_LATENCY-1] marks the cycle in which rd_data holds a requested word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_sr    <= '0;
         w_valid_q <= 1'b0;
         w_data_q  <= '0;
      end else begin
         vld_sr    <= (vld_sr << 1) | RD_LATENCY'(rd_en_q);
         w_valid_q <= vld_sr[RD_LATENCY-1];
         if (vld_sr[RD_LATENCY-1]) begin
            w_data_q <= bus.rd_data;
         end
      end
   end

endmodule

// File: tb/tb_weight_prefetch_feeder.sv
// Bench for weight_prefetch_feeder: two instances (read latency 1 and 3) share
// stimulus and an SRAM image; traces are checked against tables and a cycle-offset model.
module tb_weight_prefetch_feeder;
   localparam int WB   = 8;
   localparam int ROWS = 4;
   localparam int COLS = 2;
   localparam int AW   = 10;
   localparam int DWID = COLS * WB;
   localparam int MAXC = 256;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] tile_base = '0;
   logic          busy1, done1, busy3, done3;

   always #5 clk = ~clk;

   weight_prefetch_feeder_if #(.W_BITWIDTH(WB), .COL_NUM(COLS), .ADDR_WIDTH(AW)) bus1 ();
   weight_prefetch_feeder_if #(.W_BITWIDTH(WB), .COL_NUM(COLS), .ADDR_WIDTH(AW)) bus3 ();

   weight_prefetch_feeder #(.W_BITWIDTH(WB), .ROW_NUM(ROWS), .COL_NUM(COLS),
                            .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .tile_base(tile_base),
      .busy(busy1), .done(done1), .bus(bus1));

   weight_prefetch_feeder #(.W_BITWIDTH(WB), .ROW_NUM(ROWS), .COL_NUM(COLS),
                            .ADDR_WIDTH(AW), .RD_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .tile_base(tile_base),
      .busy(busy3), .done(done3), .bus(bus3));

   // SRAM image; unrequested cycles return junk so the feeder must gate on valid
   logic [DWID-1:0] mem [0:1023];
   logic [DWID-1:0] p1;
   logic [DWID-1:0] p3 [0:2];

   always @(posedge clk) begin
      p1    <= bus1.rd_en ? mem[bus1.rd_addr] : DWID'($urandom);
      p3[0] <= bus3.rd_en ? mem[bus3.rd_addr] : DWID'($urandom);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign bus1.rd_data = p1;
   assign bus3.rd_data = p3[2];

   // lane-0 slice of a 4-row MAC column fed by the latency-1 instance
   logic [WB-1:0] pe [0:ROWS-1];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < ROWS; r++) pe[r] <= '0;
      end else if (bus1.w_valid_out) begin
         pe[0] <= bus1.w_data_out[WB-1:0];
         for (int r = 1; r < ROWS; r++) pe[r] <= pe[r-1];
      end
   end

   bit            st_start [MAXC];
   logic [AW-1:0] st_base  [MAXC];
   bit            st_rst   [MAXC];
   logic [30:0]   tr1 [MAXC];
   logic [30:0]   tr3 [MAXC];
   logic [WB-1:0] pe7 [ROWS];

   int total = 0;
   int bad   = 0;

   typedef struct {
      int            lat;
      int            cyc;
      bit            by, dn, re, pf, wv;
      logic [AW-1:0] ad;
      logic [DWID-1:0] wd;
   } vec_t;
   vec_t vt [$];

   function automatic logic [30:0] pack(input logic by, input logic dn, input logic re,
                                        input logic [AW-1:0] ad, input logic pf,
                                        input logic wv, input logic [DWID-1:0] wd);
      return {by, dn, re, ad, pf, wv, wd};
   endfunction

   // rd_addr is only meaningful while rd_en is expected high
   task automatic cmp(input string nm, input int c, input logic [30:0] got, input logic [30:0] exp_v);
      if (!exp_v[28]) begin
         got[27:18]   = '0;
         exp_v[27:18] = '0;
      end
      total++;
      if (got !== exp_v) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, c, got, exp_v);
      end
   endtask

   task automatic clear_stim();
      for (int c = 0; c < MAXC; c++) begin
         st_start[c] = 1'b0;
         st_base[c]  = '0;
         st_rst[c]   = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_seq(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         rst_n     = !st_rst[c];
         start     = st_start[c];
         tile_base = st_base[c];
         @(negedge clk);
         tr1[c] = pack(busy1, done1, bus1.rd_en, bus1.rd_addr, bus1.prefetch_out,
                       bus1.w_valid_out, bus1.w_data_out);
         tr3[c] = pack(busy3, done3, bus3.rd_en, bus3.rd_addr, bus3.prefetch_out,
                       bus3.w_valid_out, bus3.w_data_out);
         if (c == 7) for (int r = 0; r < ROWS; r++) pe7[r] = pe[r];
      end
      @(posedge clk); #1;
      start = 1'b0;
      rst_n = 1'b1;
   endtask

   // Expected outputs from the tile timing rules, expressed as offsets from the accept cycle
   task automatic check_model(input int n, input int lat, input string tag);
      bit              act;
      int              s, d, k;
      logic [AW-1:0]   b;
      logic [DWID-1:0] lastw;
      bit              by, dn, re, pf, wv;
      logic [AW-1:0]   ad;
      act = 1'b0; s = 0; b = '0; lastw = '0;
      for (int c = 0; c < n; c++) begin
         by = 0; dn = 0; re = 0; pf = 0; wv = 0; ad = '0;
         if (st_rst[c]) begin
            act   = 1'b0;
            lastw = '0;
         end else if (act) begin
            d  = c - s;
            pf = (d == 1);
            re = (d >= 1 && d <= ROWS);
            if (re) ad = b + AW'(ROWS - d);
            if (d >= lat + 2 && d <= lat + 1 + ROWS) begin
               k     = d - lat - 2;
               wv    = 1'b1;
               lastw = mem[b + AW'(ROWS - 1 - k)];
            end
            by = (d >= 1 && d <= lat + ROWS + 1);
            dn = (d == lat + ROWS + 2);
            if (dn) act = 1'b0;
         end
         cmp(tag, c, (lat == 1) ? tr1[c] : tr3[c], pack(by, dn, re, ad, pf, wv, lastw));
         if (!st_rst[c] && st_start[c] && !by) begin
            act = 1'b1;
            s   = c;
            b   = st_base[c];
         end
      end
   endtask

   initial begin
      logic [AW-1:0] wrap_exp [4];

      for (int i = 0; i < 1024; i++) mem[i] = DWID'($urandom);
      mem[10'h010] = 16'h0201;
      mem[10'h011] = 16'h0403;
      mem[10'h012] = 16'h0605;
      mem[10'h013] = 16'h0807;

      //            lat cyc by dn re pf wv  addr     wdata
      vt.push_back('{1, 0, 0, 0, 0, 0, 0, 10'h000, 16'h0000});
      vt.push_back('{1, 1, 1, 0, 1, 1, 0, 10'h013, 16'h0000});
      vt.push_back('{1, 2, 1, 0, 1, 0, 0, 10'h012, 16'h0000});
      vt.push_back('{1, 3, 1, 0, 1, 0, 1, 10'h011, 16'h0807});
      vt.push_back('{1, 4, 1, 0, 1, 0, 1, 10'h010, 16'h0605});
      vt.push_back('{1, 5, 1, 0, 0, 0, 1, 10'h000, 16'h0403});
      vt.push_back('{1, 6, 1, 0, 0, 0, 1, 10'h000, 16'h0201});
      vt.push_back('{1, 7, 0, 1, 0, 0, 0, 10'h000, 16'h0201});
      vt.push_back('{1, 8, 0, 0, 0, 0, 0, 10'h000, 16'h0201});
      vt.push_back('{3, 1, 1, 0, 1, 1, 0, 10'h013, 16'h0000});
      vt.push_back('{3, 4, 1, 0, 1, 0, 0, 10'h010, 16'h0000});
      vt.push_back('{3, 5, 1, 0, 0, 0, 1, 10'h000, 16'h0807});
      vt.push_back('{3, 8, 1, 0, 0, 0, 1, 10'h000, 16'h0201});
      vt.push_back('{3, 9, 0, 1, 0, 0, 0, 10'h000, 16'h0201});

      // basic tile at 0x010
      clear_stim();
      st_start[0] = 1'b1;
      st_base[0]  = 10'h010;
      do_reset();
      run_seq(14);
      foreach (vt[i])
         cmp($sformatf("table_lat%0d", vt[i].lat), vt[i].cyc,
             (vt[i].lat == 1) ? tr1[vt[i].cyc] : tr3[vt[i].cyc],
             pack(vt[i].by, vt[i].dn, vt[i].re, vt[i].ad, vt[i].pf, vt[i].wv, vt[i].wd));
      for (int r = 0; r < ROWS; r++) begin
         total++;
         if (pe7[r] !== WB'(2 * r + 1)) begin
            bad++;
            $display("FAIL pe_row%0d got=%h expected=%h", r, pe7[r], WB'(2 * r + 1));
         end
      end
      check_model(14, 1, "basic_lat1");
      check_model(14, 3, "basic_lat3");

      // address wrap from 0x3FE
      clear_stim();
      st_start[0] = 1'b1;
      st_base[0]  = 10'h3FE;
      do_reset();
      run_seq(14);
      wrap_exp[0] = 10'h001; wrap_exp[1] = 10'h000; wrap_exp[2] = 10'h3FF; wrap_exp[3] = 10'h3FE;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (tr1[k+1][27:18] !== wrap_exp[k]) begin
            bad++;
            $display("FAIL wrap_addr k=%0d got=%h expected=%h", k, tr1[k+1][27:18], wrap_exp[k]);
         end
      end
      check_model(14, 1, "wrap_lat1");
      check_model(14, 3, "wrap_lat3");

      // starts while busy are dropped; start in the done cycle chains
      clear_stim();
      st_start[0] = 1'b1; st_base[0] = 10'h010;
      st_start[2] = 1'b1; st_base[2] = 10'h100;
      st_start[5] = 1'b1; st_base[5] = 10'h200;
      st_start[7] = 1'b1; st_base[7] = 10'h012;
      do_reset();
      run_seq(22);
      total++;
      if (tr1[3][17] !== 1'b0 || tr1[6][17] !== 1'b0) begin
         bad++;
         $display("FAIL busy_start_ignored pf3=%b pf6=%b expected=0,0", tr1[3][17], tr1[6][17]);
      end
      total++;
      if (tr1[8][17] !== 1'b1) begin
         bad++;
         $display("FAIL back_to_back_prefetch got=%b expected=1", tr1[8][17]);
      end
      check_model(22, 1, "busy_lat1");
      check_model(22, 3, "busy_lat3");

      // reset mid-stream, then a clean load
      clear_stim();
      st_start[0] = 1'b1; st_base[0] = 10'h010;
      st_rst[4]   = 1'b1;
      st_rst[5]   = 1'b1;
      st_start[8] = 1'b1; st_base[8] = 10'h010;
      do_reset();
      run_seq(22);
      total++;
      if (tr1[4] !== 31'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h expected=0", tr1[4]);
      end
      for (int c = 5; c < 10; c++) begin
         total++;
         if (tr1[c][16] !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_beat cyc=%0d got=%b expected=0", c, tr1[c][16]);
         end
      end
      check_model(22, 1, "reset_lat1");
      check_model(22, 3, "reset_lat3");

      // random traffic, including zero weights and occasional resets
      for (int rnd = 0; rnd < 4; rnd++) begin
         for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? '0 : DWID'($urandom);
         clear_stim();
         for (int c = 0; c < 200; c++) begin
            st_start[c] = ($urandom_range(0, 5) == 0);
            st_base[c]  = AW'($urandom);
            st_rst[c]   = ($urandom_range(0, 99) == 0);
         end
         do_reset();
         run_seq(200);
         check_model(200, 1, $sformatf("rand%0d_lat1", rnd));
         check_model(200, 3, $sformatf("rand%0d_lat3", rnd));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
